mole_round_ctrl: RTL and testbench

//  Game sequencer for the 4-hole whack-a-mole display. Starts and ends rounds, times
//  the round, pops moles up pseudo-randomly, ages them out, and scores hits and misses.

---
 rtl/mole_pkg.sv | 28 ++
 rtl/mole_round_ctrl_if.sv | 28 ++
 rtl/lfsr16.sv | 36 +++
 rtl/mole_round_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mole_round_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
//   state_e     : round state (IDLE, PLAY, OVER)
//   SCORE_MAX   : upper clamp for the displayed score
//   LFSR_TAPS   : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   popcount4() : number of set bits in a 4-bit hole vector
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam int SCORE_MAX = 99;

  // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int popcount4(input logic [3:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// Player/display bundle of the whack-a-mole sequencer.
//   start, sw              : player inputs (button level, debounced hole switches)
//   mole, score, seconds   : game state read by the VGA painter and 7-seg scanner
//   playing, game_over     : round state flags
//   hit_pulse, miss_pulse  : one-cycle event strobes
// slave  : the sequencer (consumes inputs, drives game state)
// master : the player/display side
interface mole_round_ctrl_if;
  logic       start;
  logic [3:0] sw;
  logic [3:0] mole;
  logic [6:0] score;
  logic [7:0] seconds;
  logic       playing;
  logic       game_over;
  logic       hit_pulse;
  logic       miss_pulse;

  modport slave (
    input  start, sw,
    output mole, score, seconds, playing, game_over, hit_pulse, miss_pulse
  );

  modport master (
    output start, sw,
    input  mole, score, seconds, playing, game_over, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting left with feedback into bit 0.
//   clk, reset : clock and synchronous active-high reset (loads seed)
//   en         : advance one step this cycle
//   seed       : reset value (must be non-zero)
//   q          : current LFSR state
module lfsr16
  import mole_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Game sequencer for the 4-hole whack-a-mole display: starts/ends rounds,
// times the round, spawns moles from an LFSR, ages them out and keeps score.
//   clk, reset : clock and synchronous active-high reset
//   bus.start  : button level; a rising edge starts a round from IDLE/OVER
//   bus.sw     : hole switches; a rising edge on an up mole is a hit
//   bus.mole / score / seconds / playing / game_over / hit_pulse / miss_pulse
//              : registered game state and event strobes
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int          N_MOLES       = 4,
  parameter int          TICK_DIV      = 10_000_000,
  parameter int          TICKS_PER_SEC = 10,
  parameter int          GAME_SECONDS  = 60,
  parameter int          UP_TICKS      = 15,
  parameter int          SPAWN_THRESH  = 2,
  parameter int          MAX_UP        = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  mole_round_ctrl_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int UP_W   = $clog2(UP_TICKS + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);

  state_e              state_q, state_d;
  logic                start_q;
  logic [N_MOLES-1:0]  sw_q;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
  logic [7:0]          seconds_q, seconds_d;
  logic [6:0]          score_q, score_d;
  logic [N_MOLES-1:0]  mole_q, mole_d;
  logic [UP_W-1:0]     up_timer_q [N_MOLES];
  logic [UP_W-1:0]     up_timer_d [N_MOLES];
  logic                hit_pulse_q, hit_pulse_d;
  logic                miss_pulse_q, miss_pulse_d;

  logic                playing;
  logic                tick;
  logic                start_rise;
  logic [N_MOLES-1:0]  sw_rise;
  logic [N_MOLES-1:0]  hit_vec;
  logic [N_MOLES-1:0]  miss_vec;
  logic [N_MOLES-1:0]  qual_vec;
  logic [N_MOLES-1:0]  grant_vec;
  logic [15:0]         lfsr_q;

  assign playing    = (state_q == PLAY);
  assign tick       = playing && (tick_cnt_q == TICK_LAST);
  assign start_rise = bus.start & ~start_q;
  assign sw_rise    = bus.sw & ~sw_q;

  // The LFSR value seen this cycle is the pre-advance value used for spawning.
  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // Per-hole event decode. A hit masks a same-cycle expiry on that hole, and
  // only holes down at cycle start can qualify for a spawn.
  for (genvar gi = 0; gi < N_MOLES; gi++) begin : g_hole
    assign hit_vec[gi]  = playing & sw_rise[gi] & mole_q[gi];
    assign miss_vec[gi] = tick & mole_q[gi] & ~hit_vec[gi] &
                          (up_timer_q[gi] == UP_W'(1));
    assign qual_vec[gi] = tick & ~mole_q[gi] &
                          (int'(lfsr_q[4*gi +: 4]) < SPAWN_THRESH);
  end

  // Grant spawns in index order against the moles that survive this cycle.
  always_comb begin
    int n;
    n = popcount4(mole_q & ~hit_vec & ~miss_vec);
    grant_vec = '0;
    for (int i = 0; i < N_MOLES; i++) begin
      if (qual_vec[i] && (n < MAX_UP)) begin
        grant_vec[i] = 1'b1;
        n = n + 1;
      end
    end
  end

  always_comb begin
    int   net;
    logic last_sec;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    sec_cnt_d    = sec_cnt_q;
    seconds_d    = seconds_q;
    score_d      = score_q;
    mole_d       = mole_q;
    up_timer_d   = up_timer_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    net          = int'(score_q) + popcount4(hit_vec) - popcount4(miss_vec);
    last_sec     = tick && (sec_cnt_q == SEC_LAST) && (seconds_q == 8'd1);

    if (net > SCORE_MAX) begin
      net = SCORE_MAX;
    end else if (net < 0) begin
      net = 0;
    end

    unique case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d    = PLAY;
          score_d    = '0;
          seconds_d  = 8'(GAME_SECONDS);
          mole_d     = '0;
          tick_cnt_d = '0;
          sec_cnt_d  = '0;
          for (int i = 0; i < N_MOLES; i++) begin
            up_timer_d[i] = '0;
          end
        end
      end

      PLAY: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        if (tick) begin
          sec_cnt_d = (sec_cnt_q == SEC_LAST) ? '0 : sec_cnt_q + SEC_W'(1);
          if (sec_cnt_q == SEC_LAST) begin
            seconds_d = seconds_q - 8'd1;
          end
        end

        if (last_sec) begin
          // Round ends: clear the field and skip scoring for this cycle.
          state_d = OVER;
          mole_d  = '0;
          for (int i = 0; i < N_MOLES; i++) begin
            up_timer_d[i] = '0;
          end
        end else begin
          score_d      = 7'(net);
          mole_d       = (mole_q & ~hit_vec & ~miss_vec) | grant_vec;
          hit_pulse_d  = |hit_vec;
          miss_pulse_d = |miss_vec;
          for (int i = 0; i < N_MOLES; i++) begin
            if (grant_vec[i]) begin
              up_timer_d[i] = UP_W'(UP_TICKS);
            end else if (hit_vec[i]) begin
              up_timer_d[i] = '0;
            end else if (tick && mole_q[i]) begin
              up_timer_d[i] = up_timer_q[i] - UP_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      sw_q         <= '0;
      tick_cnt_q   <= '0;
      sec_cnt_q    <= '0;
      seconds_q    <= '0;
      score_q      <= '0;
      mole_q       <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      for (int i = 0; i < N_MOLES; i++) begin
        up_timer_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      start_q      <= bus.start;
      sw_q         <= bus.sw;
      tick_cnt_q   <= tick_cnt_d;
      sec_cnt_q    <= sec_cnt_d;
      seconds_q    <= seconds_d;
      score_q      <= score_d;
      mole_q       <= mole_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      for (int i = 0; i < N_MOLES; i++) begin
        up_timer_q[i] <= up_timer_d[i];
      end
    end
  end

  assign bus.mole       = mole_q;
  assign bus.score      = score_q;
  assign bus.seconds    = seconds_q;
  assign bus.playing    = playing;
  assign bus.game_over  = (state_q == OVER);
  assign bus.hit_pulse  = hit_pulse_q;
  assign bus.miss_pulse = miss_pulse_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Scoreboard bench for mole_round_ctrl with a small, fast game configuration.
// Stimulus pushes expected output snapshots tagged with the cycle they must
// appear on; the monitor pops and compares on the falling edge.
module tb_mole_round_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  mole_round_ctrl_if bus();

  mole_round_ctrl #(
    .TICK_DIV      (4),
    .TICKS_PER_SEC (2),
    .GAME_SECONDS  (3),
    .UP_TICKS      (2),
    .SPAWN_THRESH  (16),
    .MAX_UP        (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Snapshot layout: mole[22:19] score[18:12] seconds[11:4] playing over hit miss
  typedef struct {
    int          at;
    logic [22:0] v;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  function automatic logic [22:0] snap(input int m, input int s, input int sec,
                                       input int p, input int o, input int h,
                                       input int mi);
    return {4'(m), 7'(s), 8'(sec), 1'(p), 1'(o), 1'(h), 1'(mi)};
  endfunction

  task automatic expect_at(input int at, input string nm, input logic [22:0] v);
    exp_t e;
    e.at = at;
    e.v  = v;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor
  initial begin
    logic [22:0] act;
    logic [22:0] want;
    string       nm;
    forever begin
      @(negedge clk);
      act = {bus.mole, bus.score, bus.seconds, bus.playing, bus.game_over,
             bus.hit_pulse, bus.miss_pulse};
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        want = exp_q[0].v;
        nm   = name_q[0];
        total++;
        if (exp_q[0].at != cyc || act !== want) begin
          bad++;
          $display("FAIL %s cyc=%0d got mole=%b score=%0d sec=%0d play=%b over=%b hit=%b miss=%b want mole=%b score=%0d sec=%0d play=%b over=%b hit=%b miss=%b",
                   nm, cyc, act[22:19], act[18:12], act[11:4], act[3], act[2], act[1], act[0],
                   want[22:19], want[18:12], want[11:4], want[3], want[2], want[1], want[0]);
        end else begin
          $display("check %s cyc=%0d mole=%b score=%0d sec=%0d play=%b over=%b hit=%b miss=%b ok",
                   nm, cyc, act[22:19], act[18:12], act[11:4], act[3], act[2], act[1], act[0]);
        end
        void'(exp_q.pop_front());
        void'(name_q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    int s;
    int t;
    bus.start = 1'b0;
    bus.sw    = 4'b0000;
    reset     = 1'b1;
    step(3);

    // Reset state, then 100 idle cycles with no start.
    expect_at(cyc + 1, "reset_state", snap(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    expect_at(cyc + 2, "idle_first", snap(0, 0, 0, 0, 0, 0, 0));
    expect_at(cyc + 100, "idle_100", snap(0, 0, 0, 0, 0, 0, 0));
    step(101);

    // Round 1: start, spawn, hit, hit-beats-expiry, held switch, timeout to OVER.
    bus.start = 1'b1;
    s = cyc + 1;
    expect_at(s,      "play_entry",       snap(4'b0000, 0, 3, 1, 0, 0, 0));
    expect_at(s + 4,  "tick1_spawn",      snap(4'b0011, 0, 3, 1, 0, 0, 0));
    expect_at(s + 5,  "hit_sw1",          snap(4'b0001, 1, 3, 1, 0, 1, 0));
    expect_at(s + 6,  "hit_pulse_end",    snap(4'b0001, 1, 3, 1, 0, 0, 0));
    expect_at(s + 8,  "tick2_respawn",    snap(4'b0011, 1, 2, 1, 0, 0, 0));
    expect_at(s + 12, "hit_beats_expiry", snap(4'b0110, 2, 2, 1, 0, 1, 0));
    expect_at(s + 16, "held_sw_no_rehit", snap(4'b0101, 1, 1, 1, 0, 0, 1));
    expect_at(s + 17, "miss_pulse_end",   snap(4'b0101, 1, 1, 1, 0, 0, 0));
    expect_at(s + 20, "tick5_miss",       snap(4'b0011, 0, 1, 1, 0, 0, 1));
    expect_at(s + 24, "round_over",       snap(4'b0000, 0, 0, 0, 1, 0, 0));
    expect_at(s + 30, "over_hold",        snap(4'b0000, 0, 0, 0, 1, 0, 0));
    step(1);
    bus.start = 1'b0;
    step(4);
    bus.sw = 4'b0010;
    step(7);
    bus.sw = 4'b0011;
    step(19);
    bus.sw = 4'b0000;
    step(2);

    // Round 2 from OVER: misses at score 0, start ignored in PLAY, reset mid-round.
    bus.start = 1'b1;
    t = cyc + 1;
    expect_at(t,      "restart_from_over",   snap(4'b0000, 0, 3, 1, 0, 0, 0));
    expect_at(t + 4,  "r2_tick1",            snap(4'b0011, 0, 3, 1, 0, 0, 0));
    expect_at(t + 8,  "r2_tick2_full",       snap(4'b0011, 0, 2, 1, 0, 0, 0));
    expect_at(t + 12, "miss_saturate_0",     snap(4'b1100, 0, 2, 1, 0, 0, 1));
    expect_at(t + 13, "r2_miss_pulse_end",   snap(4'b1100, 0, 2, 1, 0, 0, 0));
    expect_at(t + 16, "start_in_play_ignored", snap(4'b1100, 0, 1, 1, 0, 0, 0));
    step(1);
    bus.start = 1'b0;
    step(13);
    bus.start = 1'b1;
    step(2);
    bus.start = 1'b0;
    step(2);
    reset = 1'b1;
    expect_at(t + 18, "reset_mid_play", snap(0, 0, 0, 0, 0, 0, 0));
    step(2);
    reset = 1'b0;
    expect_at(t + 20, "idle_after_reset", snap(0, 0, 0, 0, 0, 0, 0));
    expect_at(t + 25, "idle_after_reset_5", snap(0, 0, 0, 0, 0, 0, 0));
    step(8);

    total++;
    if (bus.mole !== 4'b0000 || bus.score !== 7'd0) begin
      bad++;
      $display("FAIL final_mole_score cyc=%0d mole=%b score=%0d", cyc, bus.mole, bus.score);
    end else begin
      $display("check final_mole_score cyc=%0d mole=%b score=%0d ok", cyc, bus.mole, bus.score);
    end

    total++;
    if (bus.seconds !== 8'd0) begin
      bad++;
      $display("FAIL final_seconds cyc=%0d sec=%0d", cyc, bus.seconds);
    end else begin
      $display("check final_seconds cyc=%0d sec=%0d ok", cyc, bus.seconds);
    end

    total++;
    if (bus.playing !== 1'b0 || bus.game_over !== 1'b0) begin
      bad++;
      $display("FAIL final_state cyc=%0d play=%b over=%b", cyc, bus.playing, bus.game_over);
    end else begin
      $display("check final_state cyc=%0d play=%b over=%b ok", cyc, bus.playing, bus.game_over);
    end

    total++;
    if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin
      bad++;
      $display("FAIL final_pulses cyc=%0d hit=%b miss=%b", cyc, bus.hit_pulse, bus.miss_pulse);
    end else begin
      $display("check final_pulses cyc=%0d hit=%b miss=%b ok", cyc, bus.hit_pulse, bus.miss_pulse);
    end

    // Any snapshot the monitor never reached counts as a failure.
    while (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s never checked: due cyc=%0d now cyc=%0d", name_q[0], exp_q[0].at, cyc);
      void'(exp_q.pop_front());
      void'(name_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
